// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall controller.
//   stall_state_t       : FSM state encoding (RUN=0, MEM_WAIT=1, FLUSH=2, HAZ=3)
//   MEM_TIMEOUT_DEFAULT : default consecutive memory-wait limit before timeout
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StHaz     = 2'd3
  } stall_state_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order pipeline.
// Arbitrates memory wait > taken branch > data hazard and drives the
// freeze/flush/bubble controls combinationally from the current state and inputs.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   hazard_detection  : data-hazard stall request
//   branch_taken      : taken branch resolved in EXE
//   mem_req/mem_ready : MEM stage access and its completion
//   freeze_pc, freeze_ifid, flush_ifid, bubble_idex, freeze_back : pipeline controls
//   mem_timeout       : sticky memory-timeout flag (cleared only by reset)
//   stall_count       : stall/flush cycle counter (only with STALL_CNT_EN)
//   state_o           : current FSM state
//
// Build option: define STALL_CNT_EN to add the stall_count output and counter.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detection,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             freeze_back,
  output logic             mem_timeout,
`ifdef STALL_CNT_EN
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic [1:0]       state_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  stall_state_t      state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              mem_wait;

  assign mem_wait = mem_req & ~mem_ready;

  always_comb begin
    state_d     = state_q;
    freeze_pc   = 1'b0;
    freeze_ifid = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    freeze_back = 1'b0;

    // Outputs are forced low while reset is held, independent of other inputs.
    if (!rst) begin
      if (mem_wait) begin
        freeze_pc   = 1'b1;
        freeze_ifid = 1'b1;
        freeze_back = 1'b1;
        state_d     = StMemWait;
      end else if (branch_taken) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
        state_d     = StFlush;
      end else if (hazard_detection && (state_q != StFlush)) begin
        // In FLUSH the instruction raising the hazard is the squashed one.
        freeze_pc   = 1'b1;
        freeze_ifid = 1'b1;
        bubble_idex = 1'b1;
        state_d     = StHaz;
      end else begin
        state_d     = StRun;
      end
    end
  end

  // The wait counter counts every cycle of an uninterrupted memory wait,
  // including the one that enters MEM_WAIT, so timeout follows the Nth wait cycle.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    timeout_d = timeout_q | (mem_wait && (wait_cnt_d == WAIT_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Wraps naturally on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (freeze_pc || flush_ifid) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, hand-written
// timeout/reset sequences, then randomized stimulus against a rule-level model.
module tb_pipe_stall_ctrl;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst, hazard_detection, branch_taken, mem_req, mem_ready;
  logic freeze_pc, freeze_ifid, flush_ifid, bubble_idex, freeze_back, mem_timeout;
  logic [1:0] state_o;
`ifdef STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .hazard_detection (hazard_detection),
    .branch_taken     (branch_taken),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .freeze_pc        (freeze_pc),
    .freeze_ifid      (freeze_ifid),
    .flush_ifid       (flush_ifid),
    .bubble_idex      (bubble_idex),
    .freeze_back      (freeze_back),
    .mem_timeout      (mem_timeout),
`ifdef STALL_CNT_EN
    .stall_count      (stall_count),
`endif
    .state_o          (state_o)
  );

  // {freeze_pc, freeze_ifid, flush_ifid, bubble_idex, freeze_back, mem_timeout}
  logic [5:0] outs;
  assign outs = {freeze_pc, freeze_ifid, flush_ifid, bubble_idex, freeze_back, mem_timeout};

  localparam logic [5:0] O_ZERO = 6'b000000;
  localparam logic [5:0] O_MEMW = 6'b110010;
  localparam logic [5:0] O_BRAN = 6'b001100;
  localparam logic [5:0] O_HAZD = 6'b110100;

  typedef struct {
    logic       rst, haz, br, mreq, mrdy;
    logic [5:0] exp_out;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic b, input logic q,
                       input logic y);
    rst = r; hazard_detection = h; branch_taken = b; mem_req = q; mem_ready = y;
  endtask

  function automatic vec_t mk(input logic r, input logic h, input logic b, input logic q,
                              input logic y, input logic [5:0] eo, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.haz = h; v.br = b; v.mreq = q; v.mrdy = y;
    v.exp_out = eo; v.exp_state = es;
    return v;
  endfunction

  // Rule-level reference model state.
  int          m_state;
  int          m_wait;
  logic        m_to;
  logic [31:0] m_cnt;
  logic [5:0]  e_out;
  logic        r_rst, r_haz, r_br, r_mq, r_my;
  int          rdy_pct;

  initial begin
    //            rst haz br mreq mrdy  outputs  next state
    tbl[0]  = mk(1, 1, 1, 1, 0, O_ZERO, 2'd0);  // reset dominates everything
    tbl[1]  = mk(0, 1, 0, 0, 0, O_HAZD, 2'd3);  // load-use
    tbl[2]  = mk(0, 0, 0, 0, 0, O_ZERO, 2'd0);
    tbl[3]  = mk(0, 1, 1, 0, 0, O_BRAN, 2'd2);  // branch beats hazard
    tbl[4]  = mk(0, 1, 0, 0, 0, O_ZERO, 2'd0);  // hazard ignored in FLUSH
    tbl[5]  = mk(0, 0, 0, 1, 0, O_MEMW, 2'd1);
    tbl[6]  = mk(0, 0, 0, 1, 0, O_MEMW, 2'd1);
    tbl[7]  = mk(0, 0, 0, 1, 0, O_MEMW, 2'd1);
    tbl[8]  = mk(0, 0, 0, 1, 1, O_ZERO, 2'd0);  // ready cycle: no freeze
    tbl[9]  = mk(0, 1, 1, 1, 0, O_MEMW, 2'd1);  // all events: freeze only
    tbl[10] = mk(0, 0, 1, 1, 1, O_BRAN, 2'd2);  // ready in MEM_WAIT, branch decides
    tbl[11] = mk(0, 0, 0, 0, 0, O_ZERO, 2'd0);
    tbl[12] = mk(0, 1, 0, 0, 0, O_HAZD, 2'd3);
    tbl[13] = mk(0, 1, 0, 0, 0, O_HAZD, 2'd3);  // hazard held in HAZ
    tbl[14] = mk(0, 0, 0, 0, 0, O_ZERO, 2'd0);

    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'(O_ZERO));
    chk("reset_state", 32'(state_o), 32'd0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].haz, tbl[i].br, tbl[i].mreq, tbl[i].mrdy);
      #2;
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp_out));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(tbl[i].exp_state));
    end

`ifdef STALL_CNT_EN
    // Single load-use stall after reset counts exactly once.
    drive(1, 0, 0, 0, 0); #2; drive(0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("loaduse_stall_count", stall_count, 32'd1);
`endif

    // Timeout: flag rises after the 4th consecutive wait cycle, then sticks.
    drive(1, 0, 0, 0, 0); #2; drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("timeout_after_wait%0d", i), 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("timeout_ready%0d_freeze_back", i), 32'(freeze_back), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("timeout_sticky%0d", i), 32'(mem_timeout), 32'd1);
    end

    // Reset mid-stall: async clear, no residual freeze afterwards.
    drive(0, 0, 0, 1, 0);
    @(posedge clk); #3;
    chk("midstall_freeze", 32'(outs), 32'(O_MEMW | 6'b000001));
    rst = 1'b1;
    #1;
    chk("midstall_rst_outs", 32'(outs), 32'(O_ZERO));
    chk("midstall_rst_state", 32'(state_o), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    #2;
    chk("after_rst_outs", 32'(outs), 32'(O_ZERO));
    @(posedge clk); #1;
    chk("after_rst_state", 32'(state_o), 32'd0);

    // Randomized run against the model.
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    m_state = 0; m_wait = 0; m_to = 1'b0; m_cnt = '0;
    rdy_pct = 75;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) rdy_pct = ($urandom_range(0, 1) == 0) ? 75 : 10;
      r_rst = ($urandom_range(0, 79) == 0);
      r_haz = ($urandom_range(0, 3) == 0);
      r_br  = ($urandom_range(0, 5) == 0);
      r_mq  = ($urandom_range(0, 1) == 0);
      r_my  = ($urandom_range(0, 99) < rdy_pct);
      drive(r_rst, r_haz, r_br, r_mq, r_my);
      if (r_rst) begin
        m_state = 0; m_wait = 0; m_to = 1'b0; m_cnt = '0;
      end
      if (r_rst)                         e_out = O_ZERO;
      else if (r_mq && !r_my)            e_out = O_MEMW;
      else if (r_br)                     e_out = O_BRAN;
      else if (r_haz && m_state != 2)    e_out = O_HAZD;
      else                               e_out = O_ZERO;
      e_out[0] = m_to;
      #2;
      chk($sformatf("rnd%0d_outs", cyc), 32'(outs), 32'(e_out));
      chk($sformatf("rnd%0d_state", cyc), 32'(state_o), 32'(m_state));
      chk($sformatf("rnd%0d_flush_vs_freeze", cyc), 32'(flush_ifid & freeze_ifid), 32'd0);
`ifdef STALL_CNT_EN
      chk($sformatf("rnd%0d_stall_count", cyc), stall_count, m_cnt);
`endif
      @(posedge clk);
      if (!r_rst) begin
        if (e_out[5] || e_out[3]) m_cnt = m_cnt + 32'd1;
        if (r_mq && !r_my) begin
          m_state = 1;
          m_wait  = (m_wait + 1 > int'(TO)) ? int'(TO) : m_wait + 1;
          if (m_wait == int'(TO)) m_to = 1'b1;
        end else begin
          m_wait = 0;
          if (r_br)                      m_state = 2;
          else if (r_haz && m_state != 2) m_state = 3;
          else                           m_state = 0;
        end
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive memory-wait cycles before timeout is flagged.
REQ-002 Parameter CNT_W, default 32: stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 hazard_detection  input  1  data-hazard stall request from the hazard detection unit.
REQ-006 branch_taken  input  1  taken branch resolved in EXE.
REQ-007 mem_req  input  1  MEM stage holds a load or store.
REQ-008 mem_ready  input  1  data memory completes the access this cycle.
REQ-009 freeze_pc  output  1  hold PC.
REQ-010 freeze_ifid  output  1  hold IF/ID register.
REQ-011 flush_ifid  output  1  clear IF/ID to a NOP.
REQ-012 bubble_idex  output  1  load NOP controls into ID/EX.
REQ-013 freeze_back  output  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-014 mem_timeout  output  1  sticky memory-timeout error flag.
REQ-015 state_o  output  2  current FSM state.

Function
REQ-016 FSM states: RUN=0, MEM_WAIT=1, FLUSH=2, HAZ=3.
REQ-017 Control outputs are combinational from current state and inputs; state, wait counter, error flag and stall counter are registered.
REQ-018 Priority, highest first: memory wait > branch > hazard.
REQ-019 Memory wait (mem_req=1, mem_ready=0), in any state: assert freeze_pc, freeze_ifid and freeze_back; deassert flush_ifid and bubble_idex; next state MEM_WAIT.
REQ-020 MEM_WAIT with mem_ready=1: no freeze this cycle; next state is evaluated by REQ-021..REQ-023 from the same inputs.
REQ-021 branch_taken=1 without memory wait: assert flush_ifid and bubble_idex; next state FLUSH.
REQ-022 FLUSH state: hazard_detection ignored (stale instruction); with no memory wait or branch, all control outputs 0; next state RUN.
REQ-023 hazard_detection=1 in RUN or HAZ, without memory wait or branch: assert freeze_pc, freeze_ifid and bubble_idex; next state HAZ.
REQ-024 HAZ state with hazard_detection=0: all control outputs 0; next state RUN.
REQ-025 Wait counter increments each cycle spent in MEM_WAIT with mem_ready=0, saturates at MEM_TIMEOUT, and clears on leaving MEM_WAIT.
REQ-026 mem_timeout sets when the wait counter equals MEM_TIMEOUT and clears only on reset.
REQ-027 flush_ifid and freeze_ifid are never both 1 in the same cycle.

Reset
REQ-028 While rst=1: state RUN, wait counter 0, mem_timeout 0, stall counter 0, and every control output 0 regardless of other inputs.
REQ-029 Reset asserted mid-stall aborts the stall immediately, with no residual freeze after deassertion.

Configuration
REQ-030 Macro STALL_CNT_EN defined: add output stall_count [CNT_W-1:0], which increments in every cycle where freeze_pc=1 or flush_ifid=1 and wraps to 0 on overflow.
REQ-031 Macro STALL_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

Structure
REQ-032 Shared package pipe_pkg holds the state enum type stall_state_t and the default MEM_TIMEOUT constant.
REQ-033 No sub-module; a single module containing the FSM and the counters.

Verification
REQ-034 Reset: rst=1 with hazard_detection=1 and branch_taken=1 -> all outputs 0, state_o=0.
REQ-035 Load-use: hazard_detection=1 for 1 cycle -> freeze_pc=1, freeze_ifid=1, bubble_idex=1 that cycle; state HAZ, then RUN; with STALL_CNT_EN, stall_count=1.
REQ-036 Branch with hazard: branch_taken=1 and hazard_detection=1 -> flush_ifid=1, bubble_idex=1, freeze_pc=0; next cycle hazard_detection=1 in FLUSH -> all outputs 0.
REQ-037 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> freeze_back=1 for exactly 3 cycles; 0 on the ready cycle.
REQ-038 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th wait cycle; stays 1 after mem_ready=1 until rst.
REQ-039 Simultaneous events: mem wait, branch_taken and hazard_detection all 1 -> freeze set only, flush_ifid=0, bubble_idex=0, state MEM_WAIT.
